// File: rtl/multicycle_control_if.sv
// Control-side bundle for the multicycle datapath: instruction/zero inputs and ALU/strobe outputs.
// master = control FSM, slave = datapath/memories.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        load_pc;
  logic        pc_src;
  logic [2:0]  state;

  modport master (
    input  instr, zero,
    output alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write, load_pc, pc_src, state
  );

  modport slave (
    output instr, zero,
    input  alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write, load_pc, pc_src, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM: IF->ID->EX->MEM(+MEM_WAIT)->WB with datapath strobes.
// Optional feature macro: MULTICYCLE_CONTROL_BNE_EN (decode BNE as branch-on-nonzero).
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_ALU = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BR  = 3'd4
  } cls_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_LESS = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Returns {supported, alu_op}; f7b selects SUB only for register-register ops.
  function automatic logic [4:0] alu_map(input logic [2:0] f3, input logic f7b, input logic is_reg);
    logic [4:0] res;
    case (f3)
      3'b000:  res = {1'b1, (is_reg && f7b) ? ALU_SUB : ALU_ADD};
      3'b111:  res = {1'b1, ALU_AND};
      3'b110:  res = {1'b1, ALU_OR};
      3'b100:  res = {1'b1, ALU_XOR};
      3'b010:  res = {1'b1, ALU_LESS};
      3'b001:  res = {1'b1, ALU_SLL};
      3'b101:  res = {1'b1, f7b ? ALU_SRA : ALU_SRL};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_branch;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_alu_op;
  logic        r_alu_src;
  cls_t        r_cls;
  logic        r_bne;

  cls_t        w_dec_cls;
  logic [3:0]  w_dec_op;
  logic        w_dec_src;
  logic        w_dec_bne;
  logic [4:0]  w_map;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic        w_f7b;
  logic        w_unused_ir;

  assign w_opcode    = r_ir[6:0];
  assign w_f3        = r_ir[14:12];
  assign w_f7b       = r_ir[30];
  // Register/immediate fields belong to the datapath, not to control.
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  // Instruction decode from the captured instruction register.
  always_comb begin
    w_dec_cls = C_NOP;
    w_dec_op  = ALU_ADD;
    w_dec_src = 1'b0;
    w_dec_bne = 1'b0;
    w_map     = 5'd0;
    case (w_opcode)
      OP_R: begin
        w_map = alu_map(w_f3, w_f7b, 1'b1);
        if (w_map[4]) begin
          w_dec_cls = C_ALU;
          w_dec_op  = w_map[3:0];
        end else begin
          w_dec_cls = C_NOP;
        end
      end
      OP_I: begin
        w_map = alu_map(w_f3, w_f7b, 1'b0);
        if (w_map[4]) begin
          w_dec_cls = C_ALU;
          w_dec_op  = w_map[3:0];
          w_dec_src = 1'b1;
        end else begin
          w_dec_cls = C_NOP;
        end
      end
      OP_LW: begin
        w_dec_cls = C_LW;
        w_dec_src = 1'b1;
      end
      OP_SW: begin
        w_dec_cls = C_SW;
        w_dec_src = 1'b1;
      end
      OP_BR: begin
        if (w_f3 == 3'b000) begin
          w_dec_cls = C_BR;
          w_dec_op  = ALU_SUB;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        end else if (w_f3 == 3'b001) begin
          w_dec_cls = C_BR;
          w_dec_op  = ALU_SUB;
          w_dec_bne = 1'b1;
`endif
        end else begin
          w_dec_cls = C_NOP;
        end
      end
      default: w_dec_cls = C_NOP;
    endcase
  end

  // Next-state: fixed sequence, MEM held while the wait counter drains.
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:    w_next = S_ID;
      S_ID:    w_next = S_EX;
      S_EX:    w_next = S_MEM;
      S_MEM:   w_next = (r_wait_cnt == 4'd0) ? S_WB : S_MEM;
      S_WB:    w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction register, registered decode, MEM wait counter and branch flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir       <= 32'd0;
      r_alu_op   <= ALU_ADD;
      r_alu_src  <= 1'b0;
      r_cls      <= C_NOP;
      r_bne      <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_branch   <= 1'b0;
    end else begin
      if (r_state == S_IF) begin
        r_ir <= bus.instr;
      end
      if (r_state == S_ID) begin
        r_alu_op  <= w_dec_op;
        r_alu_src <= w_dec_src;
        r_cls     <= w_dec_cls;
        r_bne     <= w_dec_bne;
      end
      if (r_state == S_EX) begin
        r_wait_cnt <= 4'(MEM_WAIT);
      end else if (r_state == S_MEM && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == S_IF) begin
        r_branch <= 1'b0;
      end else if (r_state == S_EX && r_cls == C_BR) begin
        r_branch <= r_bne ? ~bus.zero : bus.zero;
      end
    end
  end

  // Strobes decoded from current state and the registered instruction class.
  always_comb begin
    bus.alu_op     = r_alu_op;
    bus.alu_src    = r_alu_src;
    bus.state      = r_state;
    bus.mem_read   = (r_state == S_MEM) && (r_cls == C_LW);
    bus.mem_write  = (r_state == S_MEM) && (r_cls == C_SW);
    bus.mem_to_reg = (r_cls == C_LW) && ((r_state == S_MEM) || (r_state == S_WB));
    bus.reg_write  = (r_state == S_WB) && ((r_cls == C_ALU) || (r_cls == C_LW));
    bus.load_pc    = (r_state == S_WB);
    bus.pc_src     = (r_state == S_WB) && r_branch;
  end
endmodule
